// File: rtl/coproc_dispatch.sv
// coproc_dispatch: multi-cycle dispatcher for the FFT / encrypt / decrypt
// coprocessor instructions. Accepts one instruction at a time from decode,
// stalls the pipeline, pulses the selected unit's start and waits for its done.
// It then issues a single register-file writeback.
// Optional watchdog: define COPROC_TIMEOUT_EN to build the WAIT-state timeout
// counter and the sticky err flag (err_clr clears it). Without the macro,
// WAIT lasts until the selected done arrives and err is tied low.
module coproc_dispatch #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  input  logic [4:0]         opcode,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               issue_ready,
  output logic               stall,
  output logic [DATA_W-1:0]  co_op_a,
  output logic [DATA_W-1:0]  co_op_b,
  output logic               fft_start,
  output logic               enc_start,
  output logic               dec_start,
  input  logic               fft_done,
  input  logic               enc_done,
  input  logic               dec_done,
  input  logic [DATA_W-1:0]  fft_res,
  input  logic [DATA_W-1:0]  enc_res,
  input  logic [DATA_W-1:0]  dec_res,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               err,
  input  logic               err_clr
);

  localparam logic [4:0] OP_FFT = 5'b10010;
  localparam logic [4:0] OP_ENC = 5'b10011;
  localparam logic [4:0] OP_DEC = 5'b10100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  // Selected unit, one-hot: bit 0 = FFT, bit 1 = encrypt, bit 2 = decrypt.
  logic [2:0]         unit_q, unit_d;
  logic [2:0]         start_q, start_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               wb_en_q, wb_en_d;
  logic [RADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;

  logic [2:0]         issue_unit;
  logic               sel_done;
  logic [DATA_W-1:0]  sel_res;
  logic               timeout_hit;

  // Opcode decode: which unit (if any) the presented instruction targets
  always_comb begin
    issue_unit = 3'b000;
    case (opcode)
      OP_FFT:  issue_unit = 3'b001;
      OP_ENC:  issue_unit = 3'b010;
      OP_DEC:  issue_unit = 3'b100;
      default: issue_unit = 3'b000;
    endcase
  end

  // Only the latched unit's done/result is observed; other units are masked
  always_comb begin
    sel_done = |(unit_q & {dec_done, enc_done, fft_done});
    sel_res  = '0;
    if (unit_q[0]) begin
      sel_res = fft_res;
    end else if (unit_q[1]) begin
      sel_res = enc_res;
    end else if (unit_q[2]) begin
      sel_res = dec_res;
    end
  end

`ifdef COPROC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Watchdog: loaded in START, counts down in WAIT; a done in the last cycle still wins
  always_comb begin
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    if (state_q == S_START) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == S_WAIT) && !sel_done) begin
      if (cnt_q == '0) begin
        timeout_hit = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Sticky error: a timeout in the same cycle as err_clr leaves err set
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // No watchdog: WAIT only ends on the selected done.
  logic unused_cfg;
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign unused_cfg  = err_clr ^ (TIMEOUT == 0);
`endif

  // Dispatch sequencing: IDLE -> START -> WAIT -> WB -> IDLE, with registered outputs
  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    start_d   = 3'b000;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rd_d      = rd_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (issue_valid && (issue_unit != 3'b000)) begin
          unit_d  = issue_unit;
          start_d = issue_unit;
          op_a_d  = rs1_data;
          op_b_d  = rs2_data;
          rd_d    = rd_addr;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sel_done) begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd_q;
          wb_data_d = sel_res;
          state_d   = S_WB;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Dispatch state and output registers; reset aborts any operation at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      unit_q    <= 3'b000;
      start_q   <= 3'b000;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      start_q   <= start_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign issue_ready = (state_q == S_IDLE);
  assign stall       = (state_q != S_IDLE);
  assign co_op_a     = op_a_q;
  assign co_op_b     = op_b_q;
  assign fft_start   = start_q[0];
  assign enc_start   = start_q[1];
  assign dec_start   = start_q[2];
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_coproc_dispatch.sv
// Testbench for coproc_dispatch: directed scenarios plus randomized operations.
// Stimulus pushes expected start / writeback / error events (with the cycle
// they must appear in) into a scoreboard queue; a negedge monitor pops and
// compares whenever the DUT presents one of those events.
`timescale 1ns/1ps
module tb_coproc_dispatch;

  localparam int TO = 4;
  localparam logic [4:0] OP_FFT = 5'b10010;
  localparam logic [4:0] OP_ENC = 5'b10011;
  localparam logic [4:0] OP_DEC = 5'b10100;
  localparam int K_START = 0;
  localparam int K_WB    = 1;
  localparam int K_ERR   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid, issue_ready, stall;
  logic [4:0] opcode;
  logic [7:0] rs1_data, rs2_data, co_op_a, co_op_b;
  logic [3:0] rd_addr, wb_addr;
  logic       fft_start, enc_start, dec_start;
  logic       fft_done, enc_done, dec_done;
  logic [7:0] fft_res, enc_res, dec_res, wb_data;
  logic       wb_en, err, err_clr;

  coproc_dispatch #(.DATA_W(8), .RADDR_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .opcode(opcode),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .issue_ready(issue_ready), .stall(stall), .co_op_a(co_op_a), .co_op_b(co_op_b),
    .fft_start(fft_start), .enc_start(enc_start), .dec_start(dec_start),
    .fft_done(fft_done), .enc_done(enc_done), .dec_done(dec_done),
    .fft_res(fft_res), .enc_res(enc_res), .dec_res(dec_res),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         cyc;
    logic [2:0] unit;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         wb_seen = 0;
  logic       exp_stall = 1'b0;
  logic [3:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic       err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: which unit an opcode selects (one-hot {dec,enc,fft}), 0 if none.
  function automatic logic [2:0] unit_of(input logic [4:0] op);
    case (op)
      OP_FFT:  return 3'b001;
      OP_ENC:  return 3'b010;
      OP_DEC:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Monitor: checks stall/ready every cycle and matches output events to the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      err_prev  = 1'b0;
      last_addr = '0;
      last_data = '0;
    end else begin
      chk("stall", stall, exp_stall);
      chk("issue_ready", issue_ready, !exp_stall);
      if ({dec_start, enc_start, fft_start} != 3'b000) begin
        if (sb.size() == 0 || sb[0].kind != K_START) begin
          chk("unexpected_start", {dec_start, enc_start, fft_start}, 0);
        end else begin
          mon_e = sb.pop_front();
          $display("start unit=%b a=%02h b=%02h cycle=%0d", {dec_start, enc_start, fft_start}, co_op_a, co_op_b, cyc);
          chk("start_unit", {dec_start, enc_start, fft_start}, mon_e.unit);
          chk("start_cycle", cyc, mon_e.cyc);
          chk("co_op_a", co_op_a, mon_e.a);
          chk("co_op_b", co_op_b, mon_e.b);
        end
      end
      if (wb_en) begin
        wb_seen++;
        if (sb.size() == 0 || sb[0].kind != K_WB) begin
          chk("unexpected_wb", wb_en, 0);
        end else begin
          mon_e = sb.pop_front();
          $display("writeback addr=%0d data=%02h cycle=%0d", wb_addr, wb_data, cyc);
          chk("wb_addr", wb_addr, mon_e.addr);
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_cycle", cyc, mon_e.cyc);
          chk("co_op_a_held", co_op_a, mon_e.a);
          chk("co_op_b_held", co_op_b, mon_e.b);
          last_addr = mon_e.addr;
          last_data = mon_e.data;
        end
      end else begin
        chk("wb_addr_hold", wb_addr, last_addr);
        chk("wb_data_hold", wb_data, last_data);
      end
      if (err && !err_prev) begin
        if (sb.size() == 0 || sb[0].kind != K_ERR) begin
          chk("unexpected_err", err, 0);
        end else begin
          mon_e = sb.pop_front();
          $display("timeout err cycle=%0d", cyc);
          chk("err_cycle", cyc, mon_e.cyc);
        end
      end
      err_prev = err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input logic [2:0] m, input logic [7:0] rf, input logic [7:0] re, input logic [7:0] rdv);
    fft_done = m[0];
    enc_done = m[1];
    dec_done = m[2];
    fft_res  = rf;
    enc_res  = re;
    dec_res  = rdv;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, ":issue_ready"}, issue_ready, 1);
    chk({tag, ":stall"}, stall, 0);
    chk({tag, ":co_op_a"}, co_op_a, 0);
    chk({tag, ":co_op_b"}, co_op_b, 0);
    chk({tag, ":starts"}, {dec_start, enc_start, fft_start}, 0);
    chk({tag, ":wb_en"}, wb_en, 0);
    chk({tag, ":wb_addr"}, wb_addr, 0);
    chk({tag, ":wb_data"}, wb_data, 0);
    chk({tag, ":err"}, err, 0);
  endtask

  // One instruction from an IDLE cycle. delay>=1: selected done in WAIT cycle 'delay'.
  // delay<0: the unit never answers. noise: other units' done lines toggle meanwhile.
  task automatic do_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] rd, input logic [7:0] res, input int delay, input bit noise);
    logic [2:0] u;
    logic [2:0] m;
    exp_t       e;
    int         s;
    u = unit_of(op);
    issue_valid = 1'b1;
    opcode = op;
    rs1_data = a;
    rs2_data = b;
    rd_addr = rd;
    if (u == 3'b000) begin
      $display("issue op=%b (not a coprocessor op) cycle=%0d", op, cyc);
      repeat (3) tick();
      issue_valid = 1'b0;
      tick();
      return;
    end
    tick();
    s = cyc;
    e = '{K_START, s, u, a, b, 4'd0, 8'd0};
    sb.push_back(e);
    exp_stall = 1'b1;
    issue_valid = 1'b0;
    opcode = 5'($urandom);
    rs1_data = 8'($urandom);
    rs2_data = 8'($urandom);
    rd_addr = 4'($urandom);
    if (delay < 0) begin
`ifdef COPROC_TIMEOUT_EN
      for (int i = 0; i < TO + 1; i++) begin
        tick();
        set_done(noise ? ~u : 3'b000, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      e = '{K_ERR, s + TO + 2, 3'b000, 8'd0, 8'd0, 4'd0, 8'd0};
      sb.push_back(e);
      tick();
      set_done(3'b000, 8'd0, 8'd0, 8'd0);
      exp_stall = 1'b0;
`else
      for (int i = 0; i < 20; i++) begin
        tick();
        set_done(noise ? ~u : 3'b000, 8'($urandom), 8'($urandom), 8'($urandom));
        chk("err_tied_low", err, 0);
      end
      set_done(3'b000, 8'd0, 8'd0, 8'd0);
`endif
      return;
    end
    for (int i = 1; i <= delay; i++) begin
      tick();
      if (i < delay) begin
        set_done(noise ? ~u : 3'b000, 8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        m = noise ? 3'b111 : u;
        set_done(m, u[0] ? res : 8'($urandom), u[1] ? res : 8'($urandom), u[2] ? res : 8'($urandom));
        e = '{K_WB, cyc + 1, 3'b000, a, b, rd, res};
        sb.push_back(e);
      end
    end
    tick();
    set_done(3'b000, 8'd0, 8'd0, 8'd0);
    tick();
    exp_stall = 1'b0;
  endtask

  // Reset dropped during WAIT; a late done after release must not write back.
  task automatic reset_mid_wait(input bit already_waiting);
    exp_t e;
    int   seen;
    if (!already_waiting) begin
      issue_valid = 1'b1;
      opcode = OP_ENC;
      rs1_data = 8'h77;
      rs2_data = 8'h88;
      rd_addr = 4'd9;
      tick();
      e = '{K_START, cyc, 3'b010, 8'h77, 8'h88, 4'd0, 8'd0};
      sb.push_back(e);
      exp_stall = 1'b1;
      issue_valid = 1'b0;
      tick();
      tick();
    end
    #2;
    rst_n = 1'b0;
    exp_stall = 1'b0;
    #1;
    $display("reset asserted mid-WAIT cycle=%0d", cyc);
    check_reset_outs("midwait_reset");
    tick();
    rst_n = 1'b1;
    seen = wb_seen;
    tick();
    set_done(3'b111, 8'h5A, 8'hE1, 8'h3C);
    tick();
    set_done(3'b000, 8'd0, 8'd0, 8'd0);
    repeat (4) tick();
    chk("no_wb_after_reset", wb_seen, seen);
  endtask

  // Two ops with issue_valid held: second accept 4 cycles after the first.
  task automatic back_to_back();
    exp_t e;
    int   s;
    issue_valid = 1'b1;
    opcode = OP_FFT;
    rs1_data = 8'h12;
    rs2_data = 8'h34;
    rd_addr = 4'd3;
    tick();
    s = cyc;
    e = '{K_START, s, 3'b001, 8'h12, 8'h34, 4'd0, 8'd0};
    sb.push_back(e);
    exp_stall = 1'b1;
    opcode = OP_DEC;
    rs1_data = 8'h56;
    rs2_data = 8'h78;
    rd_addr = 4'd12;
    tick();
    set_done(3'b001, 8'hC1, 8'h00, 8'h00);
    e = '{K_WB, s + 2, 3'b000, 8'h12, 8'h34, 4'd3, 8'hC1};
    sb.push_back(e);
    tick();
    set_done(3'b000, 8'd0, 8'd0, 8'd0);
    tick();
    exp_stall = 1'b0;
    e = '{K_START, s + 4, 3'b100, 8'h56, 8'h78, 4'd0, 8'd0};
    sb.push_back(e);
    tick();
    exp_stall = 1'b1;
    issue_valid = 1'b0;
    tick();
    set_done(3'b100, 8'h00, 8'h00, 8'hD2);
    e = '{K_WB, s + 6, 3'b000, 8'h56, 8'h78, 4'd12, 8'hD2};
    sb.push_back(e);
    tick();
    set_done(3'b000, 8'd0, 8'd0, 8'd0);
    tick();
    exp_stall = 1'b0;
  endtask

  initial begin
    logic [4:0] op;
    int         r;
    issue_valid = 1'b0;
    opcode = '0;
    rs1_data = '0;
    rs2_data = '0;
    rd_addr = '0;
    err_clr = 1'b0;
    set_done(3'b000, 8'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("por");
    rst_n = 1'b1;
    tick();

    // Encrypt with done three cycles after the start pulse.
    do_op(OP_ENC, 8'h3C, 8'h5A, 4'd5, 8'hA7, 3, 1'b0);
    // Non-coprocessor opcode held valid.
    do_op(5'b00001, 8'hFF, 8'hEE, 4'd1, 8'h00, 0, 1'b0);
    // FFT with other units' done lines active before and with the real done.
    do_op(OP_FFT, 8'h01, 8'h02, 4'd7, 8'h42, 3, 1'b1);
    // Done in the first and in the last permitted WAIT cycle.
    do_op(OP_DEC, 8'hA0, 8'h0B, 4'd15, 8'h99, 1, 1'b1);
    do_op(OP_ENC, 8'h10, 8'h20, 4'd0, 8'h5E, TO + 1, 1'b1);

`ifdef COPROC_TIMEOUT_EN
    do_op(OP_DEC, 8'h44, 8'h55, 4'd2, 8'h00, -1, 1'b1);
    repeat (3) tick();
    chk("err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", err, 0);
    // err_clr held through a timeout: set wins on the expiry edge, clear next.
    err_clr = 1'b1;
    do_op(OP_FFT, 8'h66, 8'h77, 4'd4, 8'h00, -1, 1'b0);
    chk("err_set_wins", err, 1);
    tick();
    chk("err_clr_after_set", err, 0);
    err_clr = 1'b0;
    reset_mid_wait(1'b0);
`else
    do_op(OP_DEC, 8'h44, 8'h55, 4'd2, 8'h00, -1, 1'b1);
    reset_mid_wait(1'b1);
`endif

    back_to_back();

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 7);
      if (r < 2)       op = 5'($urandom);
      else if (r < 4)  op = OP_FFT;
      else if (r < 6)  op = OP_ENC;
      else             op = OP_DEC;
      do_op(op, 8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom),
            $urandom_range(1, TO + 1), 1'($urandom));
    end

    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
